// File: rtl/serial_add.sv
// serial_add: bit-serial ripple adder, LSB first, one full-adder cell plus a
// carry flop. Start/busy/done handshake; results hold until the next completion.
module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shift_a, shift_b, shift_s;
    logic             carry, c_msb_in;
    logic [CW-1:0]    cnt;

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] shift_s_nxt;
    logic             last_bit, msb_next;

    // Single full-adder cell on the current LSBs and the carry flop
    always_comb begin
        fa_s        = shift_a[0] ^ shift_b[0] ^ carry;
        fa_co       = (shift_a[0] & shift_b[0]) | (carry & (shift_a[0] ^ shift_b[0]));
        shift_s_nxt = {fa_s, shift_s[WIDTH-1:1]};
        last_bit    = (cnt == CW'(WIDTH - 1));
        msb_next    = (cnt == CW'(WIDTH - 2));
    end

    // Control FSM and datapath; start is only honoured from IDLE or DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            shift_a  <= '0;
            shift_b  <= '0;
            shift_s  <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                RUN: begin
                    shift_a <= {1'b0, shift_a[WIDTH-1:1]};
                    shift_b <= {1'b0, shift_b[WIDTH-1:1]};
                    shift_s <= shift_s_nxt;
                    carry   <= fa_co;
                    cnt     <= cnt + CW'(1);
                    // carry produced by bit WIDTH-2 is the carry into the MSB
                    if (msb_next)
                        c_msb_in <= fa_co;
                    if (last_bit) begin
                        sum   <= shift_s_nxt;
                        c_out <= fa_co;
                        ovf   <= c_msb_in ^ fa_co;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation
                    done <= 1'b0;
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b;
                        carry   <= c_in;
                        cnt     <= '0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: directed bench with a result scoreboard queue for serial_add.
module tb_serial_add;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         c_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, c_out, ovf;
    logic [W-1:0] sum;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    res_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    serial_add #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] t;
        res_t r;
        t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.s  = t[W-1:0];
        r.co = t[W];
        r.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse at a negedge; returns at the negedge after the accepting edge
    task automatic go(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici);
        a = ia; b = ib; c_in = ici; start = 1'b1;
        q.push_back(model(ia, ib, ici));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    endtask

    // n = edges seen since the accepting edge; done must appear after exactly W edges
    task automatic wait_done(input string tag, input int n0, input bit trail);
        int n;
        logic [W-1:0] hold;
        res_t e;
        n = n0;
        hold = sum;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " sum hold"}, 32'(sum), 32'(hold));
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(W));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
        if (q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, " sum"}, 32'(sum), 32'(e.s));
            chk({tag, " c_out"}, 32'(c_out), 32'(e.co));
            chk({tag, " ovf"}, 32'(ovf), 32'(e.ov));
        end
        if (trail) begin
            @(negedge clk);
            chk({tag, " done pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst c_out", 32'(c_out), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        go(8'h25, 8'h1A, 1'b0); wait_done("25+1A", 0, 1'b1);
        go(8'hFF, 8'h01, 1'b0); wait_done("FF+01", 0, 1'b1);
        go(8'h7F, 8'h01, 1'b0); wait_done("7F+01", 0, 1'b1);
        go(8'h80, 8'h80, 1'b0); wait_done("80+80", 0, 1'b1);
        go(8'h00, 8'h00, 1'b1); wait_done("00+00+1", 0, 1'b1);
        go(8'hFF, 8'hFF, 1'b1); wait_done("FF+FF+1", 0, 1'b1);

        // start during RUN is ignored
        go(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore start", 3, 1'b1);
        for (int i = 0; i < 12; i++) begin
            chk("no second done", 32'(done), 32'd0);
            chk("idle sum hold", 32'(sum), 32'h30);
            @(negedge clk);
        end

        // start held high: back-to-back results every W+1 cycles
        a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) q.push_back(model(8'h01, 8'h01, 1'b0));
        @(negedge clk);
        wait_done("hold 0", 0, 1'b0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk("hold restart busy", 32'(busy), 32'd1);
            wait_done("hold n", 0, 1'b0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold end done", 32'(done), 32'd0);
        chk("hold end busy", 32'(busy), 32'd0);

        // asynchronous reset mid-run, results nonzero beforehand
        go(8'hC0, 8'h80, 1'b0); wait_done("C0+80", 0, 1'b1);
        go(8'h33, 8'h44, 1'b0);
        void'(q.pop_back());
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async busy", 32'(busy), 32'd0);
        chk("async done", 32'(done), 32'd0);
        chk("async sum", 32'(sum), 32'd0);
        chk("async c_out", 32'(c_out), 32'd0);
        chk("async ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst idle", 32'(busy), 32'd0);
        go(8'h33, 8'h44, 1'b0); wait_done("33+44", 0, 1'b1);

        // a few random operands
        for (int i = 0; i < 6; i++) begin
            go(W'($urandom), W'($urandom), 1'($urandom));
            wait_done("random", 0, 1'b1);
        end

        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
